// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Memory-mapped UART transmitter with a byte FIFO in front of an 8N1
//   serializer. A store to TXDATA queues a byte. The serializer drains the
//   FIFO at CLKS_PER_BIT clocks per bit. STATUS is returned combinationally,
//   so a polling load completes in the same cycle.
//
//   Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
//   between data bit 7 and the stop bit (11-bit frame).
//
// Parameters
//   DATA_WIDTH   : width of wd/address/rd (>= 15)
//   FIFO_DEPTH   : FIFO entries, power of two, 2..64
//   CLKS_PER_BIT : clocks per serial bit, >= 2
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   wd      : store data, bits [7:0] used
//   address : slave address, bits [3:2] decoded (0 TXDATA, 1 STATUS)
//   we      : write strobe
//   rd      : combinational read data
//                STATUS = {count[14:8], ovf[3], busy[2], empty[1], full[0]}
//   tx      : serial output, idles high
//   busy    : frame in flight or FIFO non-empty
module uart_tx_buffered #(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic [DATA_WIDTH-1:0] address,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] rd,
   output logic                  tx,
   output logic                  busy
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BCW = $clog2(CLKS_PER_BIT);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   // serializer
   state_t         state_q, state_d;
   logic [BCW-1:0] baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     data_q, data_d;
   logic           tx_q, tx_d;

   logic [1:0] reg_sel;
   logic       full, empty, push_req, push, pop, load, baud_end;

   logic unused_bits;
   assign unused_bits = ^{wd[DATA_WIDTH-1:8], address[DATA_WIDTH-1:4], address[1:0]};

   assign reg_sel  = address[3:2];
   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign push_req = we && (reg_sel == 2'd0);
   assign push     = push_req && !full;
   assign baud_end = (baud_q == BAUD_LAST);

   // ---------------- serializer next state ----------------
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      tx_d    = tx_q;
      load    = 1'b0;

      // baud counter free-runs while a frame is active, wrapping at each bit boundary
      if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + BCW'(1);

      case (state_q)
         S_IDLE:  if (!empty) load = 1'b1;
         S_START: if (baud_end) begin
            state_d = S_DATA;
            tx_d    = data_q[0];
         end
         S_DATA: if (baud_end) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
               tx_d    = ^data_q;
`else
               state_d = S_STOP;
               tx_d    = 1'b1;
`endif
            end else begin
               bit_d = bit_q + 3'd1;
               tx_d  = data_q[bit_q + 3'd1];
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (baud_end) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
         end
`endif
         S_STOP: if (baud_end) begin
            // chain straight into the next start bit when more data is queued
            if (!empty) load = 1'b1;
            else begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (load) begin
         data_d  = mem_q[rd_ptr_q];
         state_d = S_START;
         tx_d    = 1'b0;
         baud_d  = '0;
         bit_d   = '0;
      end
   end

   assign pop = load;

   // ---------------- FIFO next state ----------------
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // a push against a full FIFO is lost even if a pop frees a slot on the same edge
      ovf_d = ovf_q;
      if (push_req && full)               ovf_d = 1'b1;
      else if (we && (reg_sel == 2'd1))   ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wd[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         tx_q     <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != S_IDLE) || !empty;

   always_comb begin
      rd = '0;
      if (reg_sel == 2'd1) begin
         rd[0]      = full;
         rd[1]      = empty;
         rd[2]      = busy;
         rd[3]      = ovf_q;
         rd[8 +: CW] = count_q;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Honors UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_tx_buffered;
   localparam int DW  = 32;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we  = 1'b0;
   logic [DW-1:0] wd  = '0;
   logic [DW-1:0] address = 32'h4;
   logic [DW-1:0] rd;
   logic          tx, busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .wd(wd), .address(address), .we(we),
      .rd(rd), .tx(tx), .busy(busy)
   );

   // single-frame vectors: line = start, d0..d7, stop in time order (MSB first)
   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
      logic       par;
   } fvec_t;

   fvec_t vecs [7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   // samples are taken right after the negedge; inputs return to a STATUS read
   task automatic tick();
      @(negedge clk);
      we      = 1'b0;
      address = 32'h4;
      wd      = '0;
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
      address = a;
      #1;
      v = rd;
      address = 32'h4;
   endtask

   task automatic drive_store(input logic [7:0] b);
      logic [31:0] r;
      r       = $urandom();
      we      = 1'b1;
      address = 32'h0;
      wd      = {r[31:8], b};
   endtask

   function automatic logic [10:0] mkseq(input logic [9:0] line, input logic par);
`ifdef UART_TX_PARITY_EN
      return {line[9:1], par, 1'b1};
`else
      return {line, 1'b0};
`endif
   endfunction

   // caller stands one cycle before the start bit; ends on the stop bit's last cycle
   task automatic expect_frame(input logic [10:0] seq, input string nm);
      for (int p = 0; p < NB; p++) begin
         logic [3:0] got;
         got = '0;
         for (int c = 0; c < CPB; c++) begin
            tick();
            got[3-c] = tx;
         end
         check($sformatf("%s_bit%0d", nm, p), 32'(got), 32'({4{seq[10-p]}}));
      end
      check({nm, "_busy_stop"}, 32'(busy), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      int bad, falls;
      logic prev;

      vecs[0] = '{8'h55, 10'b0101010101, 1'b0};
      vecs[1] = '{8'hA1, 10'b0100001011, 1'b1};
      vecs[2] = '{8'h0F, 10'b0111100001, 1'b0};
      vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
      vecs[4] = '{8'h00, 10'b0000000001, 1'b0};
      vecs[5] = '{8'hFF, 10'b0111111111, 1'b0};
      vecs[6] = '{8'h80, 10'b0000000011, 1'b1};

      // ---- reset state ----
      rst = 1'b1;
      tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      read_reg(32'h4, v); check("rst_status", v, 32'h2);
      read_reg(32'h0, v); check("rst_rd_txdata", v, 32'h0);
      tick();
      rst = 1'b0;

      bad = 0;
      repeat (20) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("idle20", 32'(bad), 32'd0);
      read_reg(32'h4, v); check("idle_status", v, 32'h2);
      read_reg(32'h8, v); check("reserved2_rd", v, 32'h0);
      read_reg(32'hC, v); check("reserved3_rd", v, 32'h0);

      // writes to reserved and STATUS must not queue anything
      we = 1'b1; address = 32'h8; wd = 32'h41;
      tick();
      we = 1'b1; address = 32'h4; wd = 32'h42;
      bad = 0;
      repeat (10) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("nonpush_writes_quiet", 32'(bad), 32'd0);
      read_reg(32'h4, v); check("nonpush_status", v, 32'h2);

      // ---- single frames from the table ----
      for (int i = 0; i < 7; i++) begin
         drive_store(vecs[i].data);
         tick();
         read_reg(32'h4, v); check($sformatf("v%0d_gap_status", i), v, 32'h104);
         check($sformatf("v%0d_gap_tx", i), 32'(tx), 32'd1);
         expect_frame(mkseq(vecs[i].line, vecs[i].par), $sformatf("v%0d", i));
         tick();
         check($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
         read_reg(32'h4, v); check($sformatf("v%0d_status_done", i), v, 32'h2);
      end

      // ---- two stores on consecutive cycles: contiguous frames ----
      drive_store(8'hA1);
      tick();
      drive_store(8'h0F);
      expect_frame(mkseq(vecs[1].line, vecs[1].par), "b2b_a1");
      expect_frame(mkseq(vecs[2].line, vecs[2].par), "b2b_0f");
      tick();
      check("b2b_busy_done", 32'(busy), 32'd0);

      // ---- six stores: sixth overflows ----
      for (int i = 0; i < 6; i++) begin
         drive_store(8'hFE);
         tick();
         if (i == 1) check("ovf_first_pop_tx", 32'(tx), 32'd0);
      end
      read_reg(32'h4, v); check("ovf_status", v, 32'h40D);
      read_reg(32'h0, v); check("ovf_rd_txdata", v, 32'h0);
      we = 1'b1; address = 32'h4; wd = 32'hFFFF_FFFF;
      tick();
      read_reg(32'h4, v); check("ovf_cleared_status", v, 32'h405);
      prev  = tx;
      falls = 1;
      for (int k = 7; k <= 5 * FRAME; k++) begin
         tick();
         if (prev === 1'b1 && tx === 1'b0) falls++;
         prev = tx;
      end
      check("ovf_busy_last", 32'(busy), 32'd1);
      tick();
      check("ovf_busy_done", 32'(busy), 32'd0);
      check("ovf_frames", 32'(falls), 32'd5);
      read_reg(32'h4, v); check("ovf_status_done", v, 32'h2);

      // ---- reset in the middle of data bit 3 ----
      drive_store(8'h00);
      tick();
      drive_store(8'h00);
      tick();
      repeat (17) tick();
      check("midrst_pre_tx", 32'(tx), 32'd0);
      rst = 1'b1;
      #1;
      check("midrst_async_tx", 32'(tx), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      read_reg(32'h4, v); check("midrst_status", v, 32'h2);
      bad = 0;
      repeat (60) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("midrst_quiet", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
